regfile_dump_reader: RTL

//   Debug/verification reader for the integer register file. On a start pulse it

---
 rtl/regfile_dump_reader.sv | 139 +++++++++++++
 1 files changed

// File: rtl/regfile_dump_reader.sv
// Walks the integer register file read port and streams {index, data} beats over
// valid/ready, with an end-of-dump marker, a done pulse and a running XOR checksum.
//
//  state  | meaning
//  IDLE   | waiting for start
//  READ   | rf_raddr = idx, capture rf_rdata into the beat registers
//  SEND   | beat presented, held until accepted
//  DONE   | one-cycle done pulse, drop busy
module regfile_dump_reader #(
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned SKIP_X0  = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    output logic [ADDR_W-1:0] rf_raddr,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [ADDR_W-1:0] dump_idx,
    output logic [DATA_W-1:0] dump_data,
    output logic              dump_last,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] checksum
);

    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_REGS - 1);
    localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'((SKIP_X0 != 0) ? 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_SEND,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] beat_idx_q, beat_idx_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              last_q, last_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] csum_q, csum_d;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        valid_d    = valid_q;
        beat_idx_d = beat_idx_q;
        data_d     = data_q;
        last_d     = last_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        csum_d     = csum_q;

        // abort beats everything outside IDLE, including a beat accepted this cycle
        if (state_q != S_IDLE && abort) begin
            state_d = S_IDLE;
            valid_d = 1'b0;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        idx_d   = FIRST_IDX;
                        csum_d  = '0;
                        busy_d  = 1'b1;
                        state_d = S_READ;
                    end
                end
                S_READ: begin
                    data_d     = rf_rdata;
                    beat_idx_d = idx_q;
                    last_d     = (idx_q == LAST_IDX);
                    valid_d    = 1'b1;
                    state_d    = S_SEND;
                end
                S_SEND: begin
                    if (valid_q && dump_ready) begin
                        valid_d = 1'b0;
                        csum_d  = csum_q ^ data_q;
                        if (last_q) begin
                            done_d  = 1'b1;
                            state_d = S_DONE;
                        end else begin
                            idx_d   = idx_q + ADDR_W'(1);
                            state_d = S_READ;
                        end
                    end
                end
                S_DONE: begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            valid_q    <= 1'b0;
            beat_idx_q <= '0;
            data_q     <= '0;
            last_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            csum_q     <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            valid_q    <= valid_d;
            beat_idx_q <= beat_idx_d;
            data_q     <= data_d;
            last_q     <= last_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            csum_q     <= csum_d;
        end
    end

    assign rf_raddr   = idx_q;
    assign dump_valid = valid_q;
    assign dump_idx   = beat_idx_q;
    assign dump_data  = data_q;
    assign dump_last  = last_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign checksum   = csum_q;

endmodule
